serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor: computes diff = a - b - bin, LSB first, one full-subtractor stage per clock.
- Uses a single difference/borrow cell iterated WIDTH times. It is the subtract-side counterpart of the team's adder datapath.
- Operands enter through a valid/ready start handshake. Results leave through a valid/ready done handshake.
- Used in area-constrained datapaths where a ripple subtractor is too large.

Parameters:
- WIDTH, default 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start_valid  input  1  operands a, b, bin are valid
- start_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  minuend, sampled on the start handshake
- b  input  WIDTH  subtrahend, sampled on the start handshake
- bin  input  1  borrow-in, sampled on the start handshake
- diff  output  WIDTH  result (a - b - bin) mod 2^WIDTH
- bout  output  1  final borrow-out; 1 when a < b + bin (unsigned)
- done_valid  output  1  diff/bout valid
- done_ready  input  1  consumer accepts the result

Behaviour:
- Reset: clk and rst_n as named above. Reset is synchronous, active-low, sampled on the rising edge of clk.
  - While rst_n is 0, the next edge forces: state=IDLE, diff=0, bout=0, done_valid=0, internal shift regs=0, counter=0.
  - start_ready is 0 while rst_n is low.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On an edge with start_valid=1: load a_sh=a, b_sh=b, br=bin, cnt=0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - start_ready=0.
  - Each edge computes on bit 0:
    - d = a_sh[0] ^ b_sh[0] ^ br
    - br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br)
  - Each edge also:
    - shifts d into the result shift reg from the MSB side,
    - shifts a_sh and b_sh right by 1,
    - sets br = br_next,
    - increments cnt.
  - On the edge where cnt = WIDTH-1: diff takes its final value, bout=br_next, done_valid=1, go to DONE.
  - cnt width is $clog2(WIDTH)+1.
- Latency:
  - If the start handshake occurs at edge T, done_valid rises after edge T+WIDTH.
  - Exactly WIDTH RUN cycles, independent of operand values.
- DONE:
  - diff, bout and done_valid are held stable.
  - On an edge with done_ready=1: done_valid=0, go to IDLE.
  - diff/bout retain their values after the handoff until the next result overwrites them.
- Back-to-back operation:
  - start_ready=0 in the DONE cycle, so at least one IDLE cycle separates results. Throughput is one result per WIDTH+2 cycles minimum.
  - start_valid asserted outside IDLE is ignored; the operands are not captured.
  - Operand inputs may change freely after the start handshake.
- Boundary cases:
  - a=b with bin=0: diff=0, bout=0.
  - a=0, b=2^WIDTH-1, bin=1: diff=0, bout=1 (full wrap).
  - done_ready held high in IDLE or RUN has no effect.
- Reset mid-operation (in RUN or DONE): the operation is abandoned with no partial result and no done_valid pulse. The block is in IDLE after the reset edge.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, placed after bout).
  - ovf = borrow into the MSB stage XOR bout, i.e. signed two's-complement overflow of a - b - bin.
  - ovf is registered together with bout, valid while done_valid=1, reset to 0.
- Not defined: no ovf port and no overflow logic; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0 -> diff=0x1E, bout=0. done_valid rises exactly 8 edges after the start handshake.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
- Backpressure: result a=0x33, b=0x11 held with done_ready=0 for 5 cycles while start_valid=1 with new operands ->
  - diff=0x22 and bout=0 stay stable, start_ready=0, new operands not captured;
  - after done_ready=1 the block returns to IDLE and the next start is accepted.
- Reset mid-RUN: rst_n=0 on the 3rd RUN cycle ->
  - next edge: done_valid=0, diff=0, start_ready=0 while rst_n is low;
  - after release, a=0xC8, b=0x64 -> diff=0x64, bout=0.
- Exhaustive sweep with WIDTH=4 over all a, b, bin combinations (512 ops) ->
  - diff and bout match the reference model (a-b-bin) mod 16 and borrow for every combination;
  - latency is always 4.
- With SERIAL_SUB_OVF_EN, WIDTH=8:
  - a=0x80, b=0x01, bin=0 -> diff=0x7F, ovf=1.
  - a=0x7F, b=0x01 -> diff=0x7E, ovf=0.
  - a=0x7F, b=0xFF -> diff=0x80, ovf=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, computed LSB
//   first with a single full-subtractor cell, one bit per clock.
//   Operands arrive on a valid/ready start handshake; the result leaves on a
//   valid/ready done handshake. WIDTH RUN cycles per operation.
//
// Parameters
//   WIDTH        operand/result width, 2..64 (default 8)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start_valid  a/b/bin are valid
//   start_ready  block can accept operands (IDLE only, low during reset)
//   a, b, bin    minuend, subtrahend, borrow-in (captured on start handshake)
//   diff         result (a - b - bin) mod 2^WIDTH
//   bout         final borrow-out (a < b + bin, unsigned)
//   ovf          signed overflow of a - b - bin (only with SERIAL_SUB_OVF_EN)
//   done_valid   diff/bout (and ovf) are valid
//   done_ready   consumer accepts the result
//
// Build option
//   SERIAL_SUB_OVF_EN  when defined, adds the ovf output and its logic.

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             d;
    logic             br_next;
    logic             last;

    // Single full-subtractor cell working on bit 0 of the shift registers.
    always_comb begin
        d       = a_sh[0] ^ b_sh[0] ^ br;
        br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        last    = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_ready = 1'b0;
        case (state)
            IDLE: begin
                start_ready = rst_n;
                if (start_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // diff is a separate register from res_sh so the previous result stays
    // visible while the next operation is shifting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            bout       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf        <= 1'b0;
`endif
            done_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= br_next;
                    cnt    <= cnt + CNT_W'(1);
                    res_sh <= {d, res_sh[WIDTH-1:1]};
                    if (last) begin
                        diff       <= {d, res_sh[WIDTH-1:1]};
                        bout       <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        // br is the borrow into the MSB stage at this point.
                        ovf        <= br ^ br_next;
`endif
                        done_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        done_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Bench for serial_subtractor. Two instances: WIDTH=8 for directed
//   vectors, backpressure and mid-operation reset; WIDTH=4 for an exhaustive
//   sweep. An arithmetic reference model feeds a queue per instance and one
//   compare process checks every cycle on the falling edge. Inputs change
//   1 time unit after the rising edge.

module tb_serial_subtractor;

    logic clk;
    logic rst_n;

    logic       sv8, sr8, bin8, bout8, dv8, dr8;
    logic [7:0] a8, b8, diff8;
    logic       sv4, sr4, bin4, bout4, dv4, dr4;
    logic [3:0] a4, b4, diff4;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf8, ovf4;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (sv8),
        .start_ready (sr8),
        .a           (a8),
        .b           (b8),
        .bin         (bin8),
        .diff        (diff8),
        .bout        (bout8),
`ifdef SERIAL_SUB_OVF_EN
        .ovf         (ovf8),
`endif
        .done_valid  (dv8),
        .done_ready  (dr8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (sv4),
        .start_ready (sr4),
        .a           (a4),
        .b           (b4),
        .bin         (bin4),
        .diff        (diff4),
        .bout        (bout4),
`ifdef SERIAL_SUB_OVF_EN
        .ovf         (ovf4),
`endif
        .done_valid  (dv4),
        .done_ready  (dr4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       ovf;
        logic       bout;
        logic [7:0] diff;
    } exp_t;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int w, input int av, input int bv, input int bi);
        exp_t m;
        int   modv, half, full, sa, sb, sr;
        modv   = 1 << w;
        half   = 1 << (w - 1);
        full   = av - bv - bi;
        sa     = (av >= half) ? av - modv : av;
        sb     = (bv >= half) ? bv - modv : bv;
        sr     = sa - sb - bi;
        m.diff = 8'((full + modv) % modv);
        m.bout = (av < bv + bi);
        m.ovf  = (sr < -half) || (sr > half - 1);
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h @%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    exp_t q8[$];
    exp_t q4[$];
    int   cyc = 0;
    int   pend8 = -1;
    int   pend4 = -1;
    logic prev_rst_low = 1'b0;
    logic prev_dv8 = 1'b0;
    logic prev_dv4 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (prev_rst_low) begin
            chk("rst_dv8", 64'(dv8), 64'd0);
            chk("rst_diff8", 64'(diff8), 64'd0);
            chk("rst_bout8", 64'(bout8), 64'd0);
            chk("rst_dv4", 64'(dv4), 64'd0);
            chk("rst_diff4", 64'(diff4), 64'd0);
            chk("rst_bout4", 64'(bout4), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
            chk("rst_ovf8", 64'(ovf8), 64'd0);
            chk("rst_ovf4", 64'(ovf4), 64'd0);
`endif
        end
        if (!rst_n) begin
            chk("rst_ready8", 64'(sr8), 64'd0);
            chk("rst_ready4", 64'(sr4), 64'd0);
        end

        if (dv8 === 1'b1) begin
            chk("busy_ready8", 64'(sr8), 64'd0);
            if (q8.size() == 0) begin
                chk("spurious_done8", 64'(dv8), 64'd0);
            end else begin
                chk("model_diff8", 64'(diff8), 64'(q8[0].diff));
                chk("model_bout8", 64'(bout8), 64'(q8[0].bout));
`ifdef SERIAL_SUB_OVF_EN
                chk("model_ovf8", 64'(ovf8), 64'(q8[0].ovf));
`endif
            end
            if (prev_dv8 !== 1'b1) begin
                if (pend8 < 0) chk("rise_no_start8", 64'(dv8), 64'd0);
                else chk("latency8", 64'(cyc - pend8), 64'(8 + 1));
                pend8 = -1;
            end
        end

        if (dv4 === 1'b1) begin
            chk("busy_ready4", 64'(sr4), 64'd0);
            if (q4.size() == 0) begin
                chk("spurious_done4", 64'(dv4), 64'd0);
            end else begin
                chk("model_diff4", 64'(diff4), 64'(q4[0].diff[3:0]));
                chk("model_bout4", 64'(bout4), 64'(q4[0].bout));
`ifdef SERIAL_SUB_OVF_EN
                chk("model_ovf4", 64'(ovf4), 64'(q4[0].ovf));
`endif
            end
            if (prev_dv4 !== 1'b1) begin
                if (pend4 < 0) chk("rise_no_start4", 64'(dv4), 64'd0);
                else chk("latency4", 64'(cyc - pend4), 64'(4 + 1));
                pend4 = -1;
            end
        end

        if (rst_n && sv8 && sr8) begin
            q8.push_back(model(8, int'(a8), int'(b8), int'(bin8)));
            pend8 = cyc;
        end
        if (rst_n && sv4 && sr4) begin
            q4.push_back(model(4, int'(a4), int'(b4), int'(bin4)));
            pend4 = cyc;
        end
        if (rst_n && dv8 && dr8 && q8.size() > 0) void'(q8.pop_front());
        if (rst_n && dv4 && dr4 && q4.size() > 0) void'(q4.pop_front());
        if (!rst_n) begin
            q8.delete();
            q4.delete();
            pend8 = -1;
            pend4 = -1;
        end
        prev_rst_low = !rst_n;
        prev_dv8     = dv8;
        prev_dv4     = dv4;
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready8();
        int n = 0;
        while (sr8 !== 1'b1 && n < 50) begin tick(); n++; end
        if (sr8 !== 1'b1) chk("timeout_ready8", 64'(sr8), 64'd1);
    endtask

    task automatic wait_done8();
        int n = 0;
        while (dv8 !== 1'b1 && n < 30) begin tick(); n++; end
        if (dv8 !== 1'b1) chk("timeout_done8", 64'(dv8), 64'd1);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       input logic [7:0] ed, input logic eb, input logic eo,
                       input logic hold_rdy);
        wait_ready8();
        a8 = av; b8 = bv; bin8 = bi; sv8 = 1'b1; dr8 = hold_rdy;
        tick();
        sv8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        wait_done8();
        chk("dir_diff8", 64'(diff8), 64'(ed));
        chk("dir_bout8", 64'(bout8), 64'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk("dir_ovf8", 64'(ovf8), 64'(eo));
`else
        if (eo === 1'bx) chk("dir_ovf_arg", 64'(eo), 64'd0);
`endif
        dr8 = 1'b1;
        tick();
        dr8 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        sv8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0; dr8 = 1'b0;
        sv4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0; dr4 = 1'b0;

        // Pin the model itself with hand-computed values.
        chk("pin_5a_3c", 64'(model(8, 'h5a, 'h3c, 0)), 64'({1'b0, 1'b0, 8'h1e}));
        chk("pin_00_01", 64'(model(8, 'h00, 'h01, 0)), 64'({1'b0, 1'b1, 8'hff}));
        chk("pin_10_0f", 64'(model(8, 'h10, 'h0f, 1)), 64'({1'b0, 1'b0, 8'h00}));
        chk("pin_80_01", 64'(model(8, 'h80, 'h01, 0)), 64'({1'b1, 1'b0, 8'h7f}));
        chk("pin_7f_ff", 64'(model(8, 'h7f, 'hff, 0)), 64'({1'b1, 1'b1, 8'h80}));
        chk("pin_w4_wrap", 64'(model(4, 0, 15, 1)), 64'({1'b0, 1'b1, 8'h00}));

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Directed vectors: a, b, bin, diff, bout, ovf, hold done_ready.
        op8(8'h5a, 8'h3c, 1'b0, 8'h1e, 1'b0, 1'b0, 1'b0);
        op8(8'h00, 8'h01, 1'b0, 8'hff, 1'b1, 1'b0, 1'b0);
        op8(8'h10, 8'h0f, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        op8(8'ha5, 8'ha5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        op8(8'h00, 8'hff, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        op8(8'h80, 8'h01, 1'b0, 8'h7f, 1'b0, 1'b1, 1'b0);
        op8(8'h7f, 8'h01, 1'b0, 8'h7e, 1'b0, 1'b0, 1'b0);
        op8(8'h7f, 8'hff, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);

        // Backpressure: result held while new operands are offered.
        wait_ready8();
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; sv8 = 1'b1;
        tick();
        sv8 = 1'b0;
        wait_done8();
        sv8 = 1'b1; a8 = 8'hff; b8 = 8'h00; bin8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_diff", 64'(diff8), 64'h22);
            chk("bp_bout", 64'(bout8), 64'd0);
            chk("bp_ready", 64'(sr8), 64'd0);
            chk("bp_valid", 64'(dv8), 64'd1);
            tick();
        end
        dr8 = 1'b1;
        tick();
        dr8 = 1'b0;
        chk("bp_idle_ready", 64'(sr8), 64'd1);
        chk("bp_diff_retained", 64'(diff8), 64'h22);
        tick();
        sv8 = 1'b0;
        wait_done8();
        chk("bp_next_diff", 64'(diff8), 64'hff);
        chk("bp_next_bout", 64'(bout8), 64'd0);
        dr8 = 1'b1;
        tick();
        dr8 = 1'b0;

        // Reset on the third RUN cycle.
        wait_ready8();
        a8 = 8'hab; b8 = 8'h12; bin8 = 1'b0; sv8 = 1'b1;
        tick();
        sv8 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("rstrun_dv", 64'(dv8), 64'd0);
        chk("rstrun_diff", 64'(diff8), 64'd0);
        chk("rstrun_ready", 64'(sr8), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        op8(8'hc8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b0, 1'b0);

        // Exhaustive WIDTH=4 sweep, done_ready held high throughout.
        dr4 = 1'b1;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    int n;
                    n = 0;
                    while (sr4 !== 1'b1 && n < 50) begin tick(); n++; end
                    if (sr4 !== 1'b1) chk("timeout_ready4", 64'(sr4), 64'd1);
                    a4 = 4'(ai); b4 = 4'(bi); bin4 = 1'(ci); sv4 = 1'b1;
                    tick();
                    sv4 = 1'b0;
                    a4 = 4'($urandom); b4 = 4'($urandom);
                    n = 0;
                    while (dv4 !== 1'b1 && n < 30) begin tick(); n++; end
                    if (dv4 !== 1'b1) chk("timeout_done4", 64'(dv4), 64'd1);
                    tick();
                end
            end
        end
        dr4 = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
